// File: rtl/calc1_port_scheduler_if.sv
// Request/grant bundle between the four port front-ends and the scheduler.
interface calc1_port_scheduler_if #(
    parameter int NPORTS = 4,
    parameter int CMDW   = 4
);
    logic [NPORTS-1:0]           sched_req;
    logic [NPORTS-1:0][CMDW-1:0] sched_cmd;
    logic                        arith_ready;
    logic                        shift_ready;
    logic [NPORTS-1:0]           arith_grant;
    logic [NPORTS-1:0]           shift_grant;
    logic [NPORTS-1:0]           inv_ack;
    logic [NPORTS-1:0]           proto_err;
    logic [NPORTS-1:0]           pending;
    logic [2:0]                  arith_count;
    logic [2:0]                  shift_count;

    // Port front-ends and execution units side.
    modport master (
        output sched_req, sched_cmd, arith_ready, shift_ready,
        input  arith_grant, shift_grant, inv_ack, proto_err, pending,
               arith_count, shift_count
    );

    // Scheduler side.
    modport slave (
        input  sched_req, sched_cmd, arith_ready, shift_ready,
        output arith_grant, shift_grant, inv_ack, proto_err, pending,
               arith_count, shift_count
    );
endinterface

// File: rtl/calc1_port_scheduler.sv
// Fair two-class scheduler: per-class FIFOs of port IDs, rotating tie order
// for same-edge arrivals, one-cycle grants gated by each unit's ready.
// Class index 0 = add/sub unit, 1 = shift unit. Port IDs are 2 bits.
module calc1_port_scheduler #(
    parameter int NPORTS = 4,
    parameter int CMDW   = 4
) (
    input  logic                   c_clk,
    input  logic                   reset,
    calc1_port_scheduler_if.slave  bus
);
    logic [1:0][3:0][1:0] fifo_q, fifo_d;
    logic [1:0][1:0]      head_q, head_d, tail_q, tail_d;
    logic [1:0][2:0]      cnt_q, cnt_d;
    logic [1:0][3:0]      cnt_sum;
    logic [1:0][2:0]      n_enq;
    logic [1:0]           tp_q, tp_d;
    logic [3:0]           pend_q, pend_d;
    logic [1:0][3:0]      grant_q, grant_d;
    logic [3:0]           inv_q, inv_d, perr_q, perr_d;
    logic [1:0]           rdy, pop;
    logic [3:0]           popmask, busy;
    logic [1:0][3:0]      enq;
    logic [1:0]           p, wr_idx;

    // Pops first (from registered heads), then classify requests against post-pop pending.
    always_comb begin
        rdy     = {bus.shift_ready, bus.arith_ready};
        pop     = '0;
        grant_d = '0;
        for (int c = 0; c < 2; c++) begin
            pop[c] = (cnt_q[c] != 3'd0) && rdy[c];
            if (pop[c])
                grant_d[c][fifo_q[c][head_q[c]]] = 1'b1;
        end
        popmask = grant_d[0] | grant_d[1];
        busy    = pend_q & ~popmask;
        enq     = '0;
        inv_d   = '0;
        perr_d  = '0;
        for (int i = 0; i < 4; i++) begin
            if (bus.sched_req[i]) begin
                if (busy[i]) begin
                    perr_d[i] = 1'b1;
                end else begin
                    case (bus.sched_cmd[i])
                        CMDW'(1), CMDW'(2): enq[0][i] = 1'b1;
                        CMDW'(5), CMDW'(6): enq[1][i] = 1'b1;
                        default:            inv_d[i]  = 1'b1;
                    endcase
                end
            end
        end
    end

    // Append accepted ports in rotating order starting at tp; update pointers and counts.
    always_comb begin
        fifo_d = fifo_q;
        n_enq  = '0;
        p      = '0;
        wr_idx = '0;
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 4; k++) begin
                p = tp_q + 2'(k);
                if (enq[c][p]) begin
                    wr_idx            = tail_q[c] + n_enq[c][1:0];
                    fifo_d[c][wr_idx] = p;
                    n_enq[c]          = n_enq[c] + 3'd1;
                end
            end
        end
        for (int c = 0; c < 2; c++) begin
            head_d[c]  = head_q[c] + {1'b0, pop[c]};
            tail_d[c]  = tail_q[c] + n_enq[c][1:0];
            cnt_sum[c] = {1'b0, cnt_q[c]} + {1'b0, n_enq[c]} - {3'b0, pop[c]};
            cnt_d[c]   = cnt_sum[c][2:0];
        end
        pend_d = (pend_q & ~popmask) | enq[0] | enq[1];
        tp_d   = tp_q + {1'b0, (n_enq[0] >= 3'd2) || (n_enq[1] >= 3'd2)};
    end

    // State and output registers; reset drops everything queued.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            fifo_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            tp_q    <= '0;
            pend_q  <= '0;
            grant_q <= '0;
            inv_q   <= '0;
            perr_q  <= '0;
        end else begin
            fifo_q  <= fifo_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            tp_q    <= tp_d;
            pend_q  <= pend_d;
            grant_q <= grant_d;
            inv_q   <= inv_d;
            perr_q  <= perr_d;
        end
    end

    // A port is queued at most once, so occupancy can never exceed four.
    always_ff @(posedge c_clk) begin
        if (!reset) begin
            assert (cnt_sum[0] <= 4'd4 && cnt_sum[1] <= 4'd4);
        end
    end

    assign bus.arith_grant = grant_q[0];
    assign bus.shift_grant = grant_q[1];
    assign bus.inv_ack     = inv_q;
    assign bus.proto_err   = perr_q;
    assign bus.pending     = pend_q;
    assign bus.arith_count = cnt_q[0];
    assign bus.shift_count = cnt_q[1];
endmodule

// File: tb/tb_calc1_port_scheduler.sv
// Bench for calc1_port_scheduler: directed scenarios against fixed expected
// vectors plus a randomized run checked against a queue-based reference model.
module tb_calc1_port_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    calc1_port_scheduler_if bus ();

    calc1_port_scheduler dut (
        .c_clk (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: arrival-ordered queues of port IDs.
    int         aq[$];
    int         sq[$];
    logic [3:0] m_pend;
    int         m_tp;
    logic [3:0] e_ag, e_sg, e_inv, e_perr;

    function automatic logic [25:0] pack(input logic [3:0] ag, input logic [3:0] sg,
                                         input logic [3:0] inv, input logic [3:0] perr,
                                         input logic [3:0] pend, input int ac, input int sc);
        return {ag, sg, inv, perr, pend, 3'(ac), 3'(sc)};
    endfunction

    function automatic logic [25:0] obs();
        return {bus.arith_grant, bus.shift_grant, bus.inv_ack, bus.proto_err,
                bus.pending, bus.arith_count, bus.shift_count};
    endfunction

    function automatic logic [25:0] model_vec();
        return pack(e_ag, e_sg, e_inv, e_perr, m_pend, aq.size(), sq.size());
    endfunction

    function automatic logic [3:0][3:0] mk(input int c1, input int c2, input int c3, input int c4);
        return {4'(c4), 4'(c3), 4'(c2), 4'(c1)};
    endfunction

    // One clock edge of the scheduler rules, computed from the queues.
    task automatic model_edge(input logic r, input logic [3:0] rq, input logic [3:0][3:0] cm,
                              input logic ar, input logic sr);
        int na, ns, pp;
        e_ag = '0; e_sg = '0; e_inv = '0; e_perr = '0;
        if (r) begin
            aq.delete(); sq.delete(); m_pend = '0; m_tp = 0;
            return;
        end
        if (aq.size() > 0 && ar) begin
            e_ag[aq[0]] = 1'b1; m_pend[aq[0]] = 1'b0; void'(aq.pop_front());
        end
        if (sq.size() > 0 && sr) begin
            e_sg[sq[0]] = 1'b1; m_pend[sq[0]] = 1'b0; void'(sq.pop_front());
        end
        na = 0; ns = 0;
        for (int k = 0; k < 4; k++) begin
            pp = (m_tp + k) % 4;
            if (rq[pp]) begin
                if (m_pend[pp]) e_perr[pp] = 1'b1;
                else if (cm[pp] == 1 || cm[pp] == 2) begin aq.push_back(pp); m_pend[pp] = 1'b1; na++; end
                else if (cm[pp] == 5 || cm[pp] == 6) begin sq.push_back(pp); m_pend[pp] = 1'b1; ns++; end
                else e_inv[pp] = 1'b1;
            end
        end
        if (na >= 2 || ns >= 2) m_tp = (m_tp + 1) % 4;
    endtask

    task automatic tick(input logic r, input logic [3:0] rq, input logic [3:0][3:0] cm,
                        input logic ar, input logic sr);
        rst = r; bus.sched_req = rq; bus.sched_cmd = cm;
        bus.arith_ready = ar; bus.shift_ready = sr;
        @(posedge clk);
        model_edge(r, rq, cm, ar, sr);
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 4'b1111, mk(1, 5, 2, 6), 1'b1, 1'b1);
        tick(1'b1, 4'b0000, mk(0, 0, 0, 0), 1'b1, 1'b1);
        n_cmp++;
        if (obs() !== pack(0, 0, 0, 0, 0, 0, 0)) begin
            n_fail++; $display("FAIL reset_state got %h exp %h", obs(), pack(0, 0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_single();
        logic [25:0] exp_v [3];
        exp_v[0] = pack(0, 0, 0, 0, 4'b0010, 1, 0);
        exp_v[1] = pack(4'b0010, 0, 0, 0, 0, 0, 0);
        exp_v[2] = pack(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            if (k == 0) tick(1'b0, 4'b0010, mk(0, 1, 0, 0), 1'b1, 1'b1);
            else        tick(1'b0, 4'b0000, mk(0, 0, 0, 0), 1'b1, 1'b1);
            n_cmp++;
            if (obs() !== exp_v[k]) begin
                n_fail++; $display("FAIL single[%0d] got %h exp %h", k, obs(), exp_v[k]);
            end
        end
    endtask

    task automatic test_tie_rotation();
        logic [3:0] pend_e;
        tick(1'b1, 4'b0000, mk(0, 0, 0, 0), 1'b1, 1'b1);
        for (int rnd = 0; rnd < 2; rnd++) begin
            tick(1'b0, 4'b1111, mk(1, 1, 1, 1), 1'b1, 1'b1);
            n_cmp++;
            if (obs() !== pack(0, 0, 0, 0, 4'b1111, 4, 0)) begin
                n_fail++; $display("FAIL tie_enq[%0d] got %h exp %h", rnd, obs(), pack(0, 0, 0, 0, 4'b1111, 4, 0));
            end
            pend_e = 4'b1111;
            for (int k = 0; k < 4; k++) begin
                logic [3:0] g;
                g = 4'b0001 << ((k + rnd) % 4);
                pend_e = pend_e & ~g;
                tick(1'b0, 4'b0000, mk(0, 0, 0, 0), 1'b1, 1'b1);
                n_cmp++;
                if (obs() !== pack(g, 0, 0, 0, pend_e, 3 - k, 0)) begin
                    n_fail++; $display("FAIL tie_grant[%0d][%0d] got %h exp %h", rnd, k, obs(), pack(g, 0, 0, 0, pend_e, 3 - k, 0));
                end
            end
        end
    endtask

    task automatic test_dual_units();
        tick(1'b0, 4'b0011, mk(5, 2, 0, 0), 1'b1, 1'b1);
        n_cmp++;
        if (obs() !== pack(0, 0, 0, 0, 4'b0011, 1, 1)) begin
            n_fail++; $display("FAIL dual_enq got %h exp %h", obs(), pack(0, 0, 0, 0, 4'b0011, 1, 1));
        end
        tick(1'b0, 4'b0000, mk(0, 0, 0, 0), 1'b1, 1'b1);
        n_cmp++;
        if (obs() !== pack(4'b0010, 4'b0001, 0, 0, 0, 0, 0)) begin
            n_fail++; $display("FAIL dual_grant got %h exp %h", obs(), pack(4'b0010, 4'b0001, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_invalid();
        logic [25:0] exp_v [3];
        exp_v[0] = pack(0, 0, 4'b0100, 0, 0, 0, 0);
        exp_v[1] = pack(0, 0, 4'b0100, 0, 0, 0, 0);
        exp_v[2] = pack(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            if (k == 0)      tick(1'b0, 4'b0100, mk(0, 0, 7, 0), 1'b1, 1'b1);
            else if (k == 1) tick(1'b0, 4'b0100, mk(0, 0, 0, 0), 1'b1, 1'b1);
            else             tick(1'b0, 4'b0000, mk(0, 0, 0, 0), 1'b1, 1'b1);
            n_cmp++;
            if (obs() !== exp_v[k]) begin
                n_fail++; $display("FAIL invalid[%0d] got %h exp %h", k, obs(), exp_v[k]);
            end
        end
    endtask

    task automatic test_proto_stall();
        logic [25:0] exp_v [5];
        exp_v[0] = pack(0, 0, 0, 0, 4'b1000, 0, 1);
        exp_v[1] = pack(0, 0, 0, 4'b1000, 4'b1000, 0, 1);
        exp_v[2] = pack(0, 0, 0, 0, 4'b1000, 0, 1);
        exp_v[3] = pack(0, 4'b1000, 0, 0, 0, 0, 0);
        exp_v[4] = pack(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            if (k < 2) tick(1'b0, 4'b1000, mk(0, 0, 0, 6), 1'b1, 1'b0);
            else       tick(1'b0, 4'b0000, mk(0, 0, 0, 0), 1'b1, k >= 3);
            n_cmp++;
            if (obs() !== exp_v[k]) begin
                n_fail++; $display("FAIL proto[%0d] got %h exp %h", k, obs(), exp_v[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [25:0] exp_v [4];
        exp_v[0] = pack(0, 0, 0, 0, 4'b0001, 1, 0);
        exp_v[1] = pack(4'b0001, 0, 0, 0, 4'b0001, 1, 0);
        exp_v[2] = pack(4'b0001, 0, 0, 0, 0, 0, 0);
        exp_v[3] = pack(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            if (k == 0)      tick(1'b0, 4'b0001, mk(1, 0, 0, 0), 1'b0, 1'b1);
            else if (k == 1) tick(1'b0, 4'b0001, mk(2, 0, 0, 0), 1'b1, 1'b1);
            else             tick(1'b0, 4'b0000, mk(0, 0, 0, 0), 1'b1, 1'b1);
            n_cmp++;
            if (obs() !== exp_v[k]) begin
                n_fail++; $display("FAIL b2b[%0d] got %h exp %h", k, obs(), exp_v[k]);
            end
        end
    endtask

    task automatic test_reset_drop();
        tick(1'b0, 4'b0011, mk(1, 1, 0, 0), 1'b0, 1'b1);
        n_cmp++;
        if (obs() !== pack(0, 0, 0, 0, 4'b0011, 2, 0)) begin
            n_fail++; $display("FAIL drop_enq got %h exp %h", obs(), pack(0, 0, 0, 0, 4'b0011, 2, 0));
        end
        tick(1'b1, 4'b0000, mk(0, 0, 0, 0), 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick(1'b0, 4'b0000, mk(0, 0, 0, 0), 1'b1, 1'b1);
            n_cmp++;
            if (obs() !== pack(0, 0, 0, 0, 0, 0, 0)) begin
                n_fail++; $display("FAIL drop[%0d] got %h exp %h", k, obs(), pack(0, 0, 0, 0, 0, 0, 0));
            end
        end
    endtask

    task automatic test_random();
        logic [3:0]       rq;
        logic [3:0][3:0]  cm;
        int               sel;
        int               vals[4] = '{1, 2, 5, 6};
        tick(1'b1, 4'b0000, mk(0, 0, 0, 0), 1'b1, 1'b1);
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 4; i++) begin
                rq[i] = ($urandom_range(0, 9) < 4);
                sel   = $urandom_range(0, 9);
                cm[i] = (sel < 2) ? 4'($urandom_range(0, 15)) : 4'(vals[$urandom_range(0, 3)]);
            end
            tick($urandom_range(0, 49) == 0, rq, cm,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
            n_cmp++;
            if (obs() !== model_vec()) begin
                n_fail++; $display("FAIL random[%0d] got %h exp %h", n, obs(), model_vec());
            end
        end
    endtask

    initial begin
        m_pend = '0; m_tp = 0;
        e_ag = '0; e_sg = '0; e_inv = '0; e_perr = '0;
        bus.sched_req = '0; bus.sched_cmd = '0;
        bus.arith_ready = 1'b0; bus.shift_ready = 1'b0;
        test_reset();
        test_single();
        test_tie_rotation();
        test_dual_units();
        test_invalid();
        test_proto_stall();
        test_back_to_back();
        test_reset_drop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
